// File: rtl/i2c_codec_slave.sv
// I2C target modelling a codec control port: 16-bit register writes ({reg,d8},d[7:0])
// and pointer-set + repeated-START reads, with SCL/SDA oversampled on the system clock.
module i2c_codec_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_reset,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_sda_oe,
    output logic [NUM_REGS*9-1:0] o_regs,
    output logic                  o_wr_valid,
    output logic [6:0]            o_wr_addr,
    output logic [8:0]            o_wr_data,
    output logic                  o_busy
);

    localparam int unsigned REG_W = 9;
    localparam int unsigned PTR_W = 7;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_DEV_ADDR, S_ADDR_ACK, S_REG_BYTE,
        S_DATA_BYTE, S_TX_BYTE, S_TX_ACK, S_IGNORE
    } state_t;

    // ACK slot tracker: PEND drives low on the next SCL fall, DRIVE releases on the one after
    typedef enum logic [1:0] {ACK_NONE, ACK_PEND, ACK_DRIVE} ack_t;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_t             r_state, w_state_nxt;
    ack_t               r_ack, w_ack_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]         r_sh, w_sh_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic               r_d8, w_d8_nxt;
    logic               r_rw, w_rw_nxt;
    logic               r_byte_b, w_byte_b_nxt;
    logic               r_tx_next, w_tx_next_nxt;
    logic               r_sda_oe, w_sda_oe_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_wr_valid, w_wr_valid_nxt;
    logic [PTR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [REG_W-1:0]   r_wr_data, w_wr_data_nxt;
    logic [REG_W-1:0]   r_regs [NUM_REGS];

    logic               w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]         w_byte;
    logic [7:0]         w_tx_a;
    logic [CNT_W-1:0]   w_cnt_m1;
    logic               w_ptr_ok;
    logic [REG_W-1:0]   w_rd_reg;
    logic               w_we;
    logic [REG_W-1:0]   w_wdata;

    // Pad synchronisers; idle-high reset values avoid spurious edges after reset
    always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
        if (i_axi_reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= i_sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_byte     = {r_sh[6:0], r_sda_s2};
    assign w_cnt_m1   = r_cnt - 3'd1;
    assign w_ptr_ok   = ({1'b0, w_byte[7:1]} < 8'(NUM_REGS));
    assign w_tx_a     = {7'b0, w_rd_reg[8]};

    always_comb begin
        w_rd_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_ptr == PTR_W'(i)) w_rd_reg = r_regs[i];
        end
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
        if (i_axi_reset) begin
            r_state    <= S_IDLE;
            r_ack      <= ACK_NONE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_ptr      <= '0;
            r_d8       <= 1'b0;
            r_rw       <= 1'b0;
            r_byte_b   <= 1'b0;
            r_tx_next  <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= w_ack_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sh       <= w_sh_nxt;
            r_ptr      <= w_ptr_nxt;
            r_d8       <= w_d8_nxt;
            r_rw       <= w_rw_nxt;
            r_byte_b   <= w_byte_b_nxt;
            r_tx_next  <= w_tx_next_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = r_ack;
        w_cnt_nxt      = r_cnt;
        w_sh_nxt       = r_sh;
        w_ptr_nxt      = r_ptr;
        w_d8_nxt       = r_d8;
        w_rw_nxt       = r_rw;
        w_byte_b_nxt   = r_byte_b;
        w_tx_next_nxt  = r_tx_next;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_we           = 1'b0;
        w_wdata        = '0;

        if (w_start) begin
            w_state_nxt   = S_DEV_ADDR;
            w_cnt_nxt     = 3'd7;
            w_sda_oe_nxt  = 1'b0;
            w_ack_nxt     = ACK_NONE;
            w_tx_next_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_ack_nxt     = ACK_NONE;
            w_tx_next_nxt = 1'b0;
        end else begin
            if (w_scl_fall && r_ack == ACK_PEND) begin
                w_sda_oe_nxt = 1'b1;
                w_ack_nxt    = ACK_DRIVE;
            end else if (w_scl_fall && r_ack == ACK_DRIVE) begin
                w_sda_oe_nxt = 1'b0;
                w_ack_nxt    = ACK_NONE;
                if (r_state == S_ADDR_ACK) begin
                    w_cnt_nxt = 3'd7;
                    if (r_rw) begin
                        w_state_nxt  = S_TX_BYTE;
                        w_sh_nxt     = w_tx_a;
                        w_byte_b_nxt = 1'b0;
                        w_sda_oe_nxt = ~w_tx_a[7];
                    end else begin
                        w_state_nxt = S_REG_BYTE;
                    end
                end
            end

            case (r_state)
                S_DEV_ADDR: begin
                    if (w_scl_rise) begin
                        w_sh_nxt  = w_byte;
                        w_cnt_nxt = w_cnt_m1;
                        if (r_cnt == '0) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_byte[0];
                                w_ack_nxt   = ACK_PEND;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                S_REG_BYTE: begin
                    if (w_scl_rise && r_ack == ACK_NONE) begin
                        w_sh_nxt  = w_byte;
                        w_cnt_nxt = w_cnt_m1;
                        if (r_cnt == '0) begin
                            w_ptr_nxt = w_byte[7:1];
                            w_d8_nxt  = w_byte[0];
                            if (w_ptr_ok) begin
                                w_state_nxt = S_DATA_BYTE;
                                w_ack_nxt   = ACK_PEND;
                                w_cnt_nxt   = 3'd7;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                S_DATA_BYTE: begin
                    // Commit on the 8th sample; the ACK is still driven from IGNORE
                    if (w_scl_rise && r_ack == ACK_NONE) begin
                        w_sh_nxt  = w_byte;
                        w_cnt_nxt = w_cnt_m1;
                        if (r_cnt == '0) begin
                            w_we           = 1'b1;
                            w_wdata        = {r_d8, w_byte};
                            w_wr_valid_nxt = 1'b1;
                            w_wr_addr_nxt  = r_ptr;
                            w_wr_data_nxt  = {r_d8, w_byte};
                            w_state_nxt    = S_IGNORE;
                            w_ack_nxt      = ACK_PEND;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (w_scl_fall) begin
                        if (r_cnt == '0) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_state_nxt   = S_TX_ACK;
                            w_tx_next_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt    = w_cnt_m1;
                            w_sda_oe_nxt = ~r_sh[w_cnt_m1];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (!r_sda_s2 && !r_byte_b) begin
                            w_sh_nxt      = w_rd_reg[7:0];
                            w_byte_b_nxt  = 1'b1;
                            w_tx_next_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end else if (w_scl_fall && r_tx_next) begin
                        w_state_nxt   = S_TX_BYTE;
                        w_cnt_nxt     = 3'd7;
                        w_sda_oe_nxt  = ~r_sh[7];
                        w_tx_next_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
        if (i_axi_reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_ptr == PTR_W'(i)) r_regs[i] <= w_wdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_regs[g*REG_W +: REG_W] = r_regs[g];
    end

    assign o_sda_oe   = r_sda_oe;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Directed bench: a bit-banged I2C master drives the codec slave through write,
// read-back, wrong address, out-of-range, abort and mid-read reset scenarios.
`timescale 1ns/1ps
module tb_i2c_codec_slave;

    localparam int QC = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         scl;
    logic         sda_m;
    logic         w_sda;
    logic         o_sda_oe;
    logic [287:0] o_regs;
    logic         o_wr_valid;
    logic [6:0]   o_wr_addr;
    logic [8:0]   o_wr_data;
    logic         o_busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int oe_cyc = 0;
    int busy_cyc = 0;
    logic [6:0] last_addr = '0;
    logic [8:0] last_data = '0;

    assign w_sda = sda_m & ~o_sda_oe;

    i2c_codec_slave #(.DEV_ADDR(7'h1A), .NUM_REGS(32)) dut (
        .i_axi_clk  (clk),
        .i_axi_reset(rst),
        .i_scl      (scl),
        .i_sda      (w_sda),
        .o_sda_oe   (o_sda_oe),
        .o_regs     (o_regs),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_wr_valid) begin
            wr_cnt++;
            last_addr = o_wr_addr;
            last_data = o_wr_data;
        end
        if (o_sda_oe) oe_cyc++;
        if (o_busy) busy_cyc++;
    end

    task automatic wq(input int n = 1);
        repeat (n * QC) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b0; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl = 1'b1;   wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; wq();
        scl = 1'b1; wq(2);
        scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        sda_m = 1'b1; wq();
        scl = 1'b1;   wq();
        ack = ~w_sda; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wq();
            scl = 1'b1; wq();
            b[i] = w_sda; wq();
            scl = 1'b0;
        end
        wq();
        put_bit(~mack);
    endtask

    task automatic test_reset();
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", o_sda_oe); end
        checks++; if (o_regs !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", o_regs); end
        checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b exp 0", o_wr_valid); end
        checks++; if (o_wr_addr !== 7'd0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", o_wr_addr); end
        checks++; if (o_wr_data !== 9'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", o_wr_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    endtask

    task automatic test_write();
        int   c0;
        logic a0, a1, a2;
        c0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got %b exp 1", o_busy); end
        send_byte(8'h0B, a1);
        send_byte(8'h0A, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wr_acks got %b exp 111", {a0, a1, a2}); end
        checks++; if (wr_cnt - c0 !== 1) begin errors++; $display("FAIL wr_valid_cycles got %0d exp 1", wr_cnt - c0); end
        checks++; if (last_addr !== 7'd5) begin errors++; $display("FAIL wr_addr got %h exp 05", last_addr); end
        checks++; if (last_data !== 9'h10A) begin errors++; $display("FAIL wr_data got %h exp 10a", last_data); end
        checks++; if (o_regs[53:45] !== 9'h10A) begin errors++; $display("FAIL wr_reg5 got %h exp 10a", o_regs[53:45]); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got %b exp 0", o_busy); end
    endtask

    task automatic test_read();
        int         c0;
        logic       a0, a1, a2;
        logic [7:0] ba, bb;
        c0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0A, a1);
        i2c_start();
        send_byte(8'h35, a2);
        recv_byte(1'b1, ba);
        recv_byte(1'b0, bb);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rd_acks got %b exp 111", {a0, a1, a2}); end
        checks++; if (ba !== 8'h01) begin errors++; $display("FAIL rd_byte_a got %h exp 01", ba); end
        checks++; if (bb !== 8'h0A) begin errors++; $display("FAIL rd_byte_b got %h exp 0a", bb); end
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL rd_released got %b exp 0", o_sda_oe); end
        checks++; if (wr_cnt - c0 !== 0) begin errors++; $display("FAIL rd_no_write got %0d exp 0", wr_cnt - c0); end
        checks++; if (o_regs[53:45] !== 9'h10A) begin errors++; $display("FAIL rd_reg5 got %h exp 10a", o_regs[53:45]); end
    endtask

    task automatic test_wrong_addr();
        int   c0, oe0, b0;
        logic a0, a1, a2;
        c0 = wr_cnt; oe0 = oe_cyc; b0 = busy_cyc;
        i2c_start();
        send_byte(8'h36, a0);
        send_byte(8'h0B, a1);
        send_byte(8'h0A, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL wa_acks got %b exp 000", {a0, a1, a2}); end
        checks++; if (oe_cyc - oe0 !== 0) begin errors++; $display("FAIL wa_oe_cycles got %0d exp 0", oe_cyc - oe0); end
        checks++; if (busy_cyc - b0 !== 0) begin errors++; $display("FAIL wa_busy_cycles got %0d exp 0", busy_cyc - b0); end
        checks++; if (wr_cnt - c0 !== 0) begin errors++; $display("FAIL wa_no_write got %0d exp 0", wr_cnt - c0); end
        checks++; if (o_regs[53:45] !== 9'h10A) begin errors++; $display("FAIL wa_reg5 got %h exp 10a", o_regs[53:45]); end
    endtask

    task automatic test_out_of_range();
        int   c0;
        logic a0, a1, a2;
        c0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h50, a1);
        send_byte(8'h55, a2);
        i2c_stop();
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL oor_addr_ack got %b exp 1", a0); end
        checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL oor_reg_nack got %b exp 0", a1); end
        checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL oor_data_nack got %b exp 0", a2); end
        checks++; if (wr_cnt - c0 !== 0) begin errors++; $display("FAIL oor_no_write got %0d exp 0", wr_cnt - c0); end
    endtask

    task automatic test_abort();
        int   c0;
        logic a0, a1, a2, a3;
        c0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0B, a1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        i2c_stop();
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL ab_acks got %b exp 11", {a0, a1}); end
        checks++; if (wr_cnt - c0 !== 0) begin errors++; $display("FAIL ab_no_write got %0d exp 0", wr_cnt - c0); end
        checks++; if (o_regs[53:45] !== 9'h10A) begin errors++; $display("FAIL ab_reg5 got %h exp 10a", o_regs[53:45]); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b exp 0", o_busy); end
        // Follow-up write: reg 3 <= 9'h055 (0x06 = ptr 3, d8 0)
        c0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h06, a1);
        send_byte(8'h55, a2);
        i2c_stop();
        a3 = (wr_cnt - c0 == 1);
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL ab_next_acks_valid got %b exp 1111", {a0, a1, a2, a3}); end
        checks++; if (last_addr !== 7'd3 || last_data !== 9'h055) begin errors++; $display("FAIL ab_next_wr got %h/%h exp 03/055", last_addr, last_data); end
        checks++; if (o_regs[35:27] !== 9'h055) begin errors++; $display("FAIL ab_next_reg3 got %h exp 055", o_regs[35:27]); end
    endtask

    task automatic test_reset_mid_read();
        logic       a0, a1, a2;
        logic [7:0] ba;
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h0A, a1);
        i2c_start();
        send_byte(8'h35, a2);
        recv_byte(1'b1, ba);
        // Slave now drives bit 7 of byte B (0)
        checks++; if (o_sda_oe !== 1'b1) begin errors++; $display("FAIL rr_driving got %b exp 1", o_sda_oe); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_sda_oe !== 1'b0) begin errors++; $display("FAIL rr_async_release got %b exp 0", o_sda_oe); end
        checks++; if (o_regs !== '0) begin errors++; $display("FAIL rr_regs_clear got %h exp 0", o_regs); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        scl = 1'b1;
        sda_m = 1'b1;
        wq(2);
        test_write();
    endtask

    initial begin
        rst   = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        wq();
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_out_of_range();
        test_abort();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_codec_slave.md
Name: i2c_codec_slave

Overview:
- I2C target (responder) model of the audio codec control port, the far end of the team's I2C master.
- Decodes codec-style 16-bit writes: byte 1 = {reg[6:0], d[8]}, byte 2 = d[7:0]. Also supports pointer-set plus repeated-START reads.
- Holds a 9-bit register file on the I2C-sourced side. Used as an on-chip loopback target and as the bench responder for master bring-up.
- SCL/SDA are oversampled on the system clock; no SCL-domain logic.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address that is ACKed.
- NUM_REGS, 32, register count (1..128); register addresses >= NUM_REGS are NACKed.

Ports:
- i_axi_clk  in  1  system clock; must be >= 16x SCL rate.
- i_axi_reset  in  1  asynchronous, active-high reset.
- i_scl  in  1  I2C clock from the pad (asynchronous).
- i_sda  in  1  I2C data from the pad (asynchronous).
- o_sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- o_regs  out  NUM_REGS*9  flattened register file; reg n = bits [9n+8:9n].
- o_wr_valid  out  1  one-cycle pulse per committed register write.
- o_wr_addr  out  7  address of the committed write.
- o_wr_data  out  9  data of the committed write.
- o_busy  out  1  high from an addressed START until STOP.

Behaviour:
- Reset values: o_sda_oe=0, o_regs all 0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, state=IDLE, reg pointer=0.
- Synchronisation and edges:
  - SCL and SDA pass through 2-FF synchronisers, then a 1-cycle delayed copy feeds edge detection.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Bits are sampled on the SCL rise event.
  - o_sda_oe changes only on the cycle after an SCL fall event, giving hold time.
- START (including repeated START) from any state: bit counter = 7, state goes to DEV_ADDR, o_sda_oe=0.
- STOP from any state: state goes to IDLE, o_sda_oe=0, o_busy=0. A partial write is discarded.
- States and transitions:
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits MSB first. If bits[7:1]==DEV_ADDR, go to ADDR_ACK and set o_busy. Otherwise go to IGNORE and never drive SDA.
  - ADDR_ACK: drive low for one SCL period. On R/W=0 go to REG_BYTE. On R/W=1 go to TX_BYTE with shifter = {7'b0, reg[ptr][8]} (byte A).
  - REG_BYTE: receive 8 bits; ptr = bits[7:1], d8 = bit 0. If ptr < NUM_REGS, ACK and go to DATA_BYTE; otherwise NACK (release) and go to IGNORE.
  - DATA_BYTE: receive 8 bits. On the 8th-bit sample, commit reg[ptr] = {d8, byte}. o_wr_valid pulses on the following cycle with o_wr_addr/o_wr_data. Then ACK and go to IGNORE; any further bytes are NACKed.
  - TX_BYTE: present MSB first. Each bit is set after the SCL fall; oe = ~bit. After 8 bits, release SDA and go to TX_ACK.
  - TX_ACK: sample the master's ACK. ACK after byte A loads byte B = reg[ptr][7:0] and returns to TX_BYTE. NACK, or ACK after byte B, goes to IGNORE.
  - IGNORE: release SDA and wait for START or STOP.
- Reads use the pointer from the last REG_BYTE, even when no DATA_BYTE followed. The pointer does not auto-increment.
- START and STOP take priority over a bit sample in the same cycle.
- Reset asserted mid-transaction: SDA is released immediately (async) and the register file clears.

Test Plan:
- Write: START, 0x34, 0x0B, 0x0A, STOP → three ACKs; o_wr_valid 1 cycle with o_wr_addr=5, o_wr_data=9'h10A; o_regs[53:45]=9'h10A; o_busy low after STOP.
- Read-back: after the write, START 0x34 ACK, 0x0A ACK, Sr 0x35 ACK → slave sends 0x01; master ACK → slave sends 0x0A; master NACK, STOP → SDA released; no o_wr_valid.
- Wrong address: START 0x36 0x0B 0x0A STOP → o_sda_oe never 1; o_busy stays 0; registers unchanged.
- Out-of-range register: START 0x34, 0x50 (reg 40) → NACK on the second byte; next byte NACKed; no write.
- Abort: START 0x34 0x0B, then STOP after 4 bits of the data byte → no o_wr_valid; reg 5 unchanged; state IDLE; following transaction works normally.
- Reset mid-read: assert i_axi_reset while driving a 0 bit of byte B → o_sda_oe=0 asynchronously; o_regs=0; after release, the write scenario passes.
